// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a raw asynchronous level input into clk.
// It accepts a new level only after that level has been seen for
// DEBOUNCE_CYCLES consecutive cycles. It then emits a clean level plus
// single-cycle rise/fall strobes.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN. When defined, the block
// keeps a saturating 8-bit count of rejected glitches on glitch_cnt_o.
// When it is not defined, glitch_cnt_o is tied to zero.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_i,
  output logic       q_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       busy_o,
  output logic [7:0] glitch_cnt_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  state_t                 r_state;
  state_t                 w_stateNext;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cntNext;
  logic                   w_accept;
  logic                   r_q;
  logic                   r_rise;
  logic                   r_fall;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Plain flop chain that brings raw_i into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
    end
  end

  // State and candidate-length counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STABLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Next state: count how long the synchronised level has differed from q.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      STABLE: begin
        w_cntNext = '0;
        if (w_sync != r_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_accept = 1'b1;
          end else begin
            w_stateNext = COUNT;
            w_cntNext   = CNT_ONE;
          end
        end
      end
      COUNT: begin
        if (w_sync == r_q) begin
          w_stateNext = STABLE;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_accept    = 1'b1;
          w_stateNext = STABLE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_stateNext = STABLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // Registered level and one-cycle strobes, updated on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept & w_sync;
      r_fall <= w_accept & ~w_sync;
      if (w_accept) begin
        r_q <= w_sync;
      end
    end
  end

  assign q_o    = r_q;
  assign rise_o = r_rise;
  assign fall_o = r_fall;
  assign busy_o = (r_state == COUNT);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic       w_reject;
  logic [7:0] r_glitchCnt;

  assign w_reject = (r_state == COUNT) && (w_sync == r_q);

  // Saturating count of candidates that collapsed before acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_glitchCnt <= 8'd0;
    end else if (w_reject && (r_glitchCnt != 8'hFF)) begin
      r_glitchCnt <= r_glitchCnt + 8'd1;
    end
  end

  assign glitch_cnt_o = r_glitchCnt;
`else
  assign glitch_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: drives two debouncers from the same raw input.
// Instance 0 uses the default configuration; instance 1 uses
// DEBOUNCE_CYCLES = 1. The outputs of both are compared every cycle against
// a run-length reference model.
module tb_input_debouncer;

  localparam int SYNC = 2;
  localparam int NINST = 2;

  logic       clk;
  logic       reset;
  logic       raw_i;
  logic [1:0] q, rise, fall, busy;
  logic [7:0] gc0, gc1;

  int nChecks = 0;
  int nFails  = 0;

  // reference model state
  int   mDeb [NINST] = '{4, 1};
  int   mDiff [NINST];
  logic mQ [NINST];
  logic mRise [NINST];
  logic mFall [NINST];
  int   mGlitch [NINST];
  logic mHist [$];

  input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset), .raw_i(raw_i), .q_o(q[0]), .rise_o(rise[0]),
    .fall_o(fall[0]), .busy_o(busy[0]), .glitch_cnt_o(gc0)
  );

  input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .raw_i(raw_i), .q_o(q[1]), .rise_o(rise[1]),
    .fall_o(fall[1]), .busy_o(busy[1]), .glitch_cnt_o(gc1)
  );

  // free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mHist.delete();
    for (int k = 0; k < SYNC; k++) mHist.push_back(1'b0);
    for (int i = 0; i < NINST; i++) begin
      mDiff[i] = 0;
      mQ[i] = 1'b0;
      mRise[i] = 1'b0;
      mFall[i] = 1'b0;
      mGlitch[i] = 0;
    end
  endtask

  // One clock edge of the model: the level seen at the synchroniser
  // output is the raw sample from SYNC edges earlier.
  // A new level is taken once it has differed from q for mDeb consecutive edges.
  task automatic modelEdge(input logic v);
    logic s;
    s = mHist.pop_front();
    mHist.push_back(v);
    for (int i = 0; i < NINST; i++) begin
      mRise[i] = 1'b0;
      mFall[i] = 1'b0;
      if (s != mQ[i]) begin
        mDiff[i]++;
        if (mDiff[i] == mDeb[i]) begin
          mQ[i] = s;
          mRise[i] = s;
          mFall[i] = ~s;
          mDiff[i] = 0;
        end
      end else begin
`ifdef DEBOUNCE_GLITCH_CNT_EN
        if (mDiff[i] > 0 && mGlitch[i] < 255) mGlitch[i]++;
`endif
        mDiff[i] = 0;
      end
    end
  endtask

  task automatic compareAll();
    for (int i = 0; i < NINST; i++) begin
      checkOutput($sformatf("q%0d", i), {7'd0, q[i]}, {7'd0, mQ[i]});
      checkOutput($sformatf("rise%0d", i), {7'd0, rise[i]}, {7'd0, mRise[i]});
      checkOutput($sformatf("fall%0d", i), {7'd0, fall[i]}, {7'd0, mFall[i]});
      checkOutput($sformatf("busy%0d", i), {7'd0, busy[i]},
                  {7'd0, (mDiff[i] > 0)});
    end
    checkOutput("glitch0", gc0, 8'(mGlitch[0]));
    checkOutput("glitch1", gc1, 8'(mGlitch[1]));
  endtask

  // Called at a negedge: drive raw_i, let one rising edge pass,
  // then compare at the following negedge.
  task automatic applyStimulus(input logic v, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      raw_i = v;
      @(posedge clk);
      modelEdge(v);
      @(negedge clk);
      compareAll();
    end
  endtask

  // Called at a negedge: assert reset between edges and check that every
  // output clears immediately. Then release reset at a later negedge.
  task automatic doReset();
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < NINST; i++) begin
      checkOutput($sformatf("rstQ%0d", i), {7'd0, q[i]}, 8'd0);
      checkOutput($sformatf("rstRise%0d", i), {7'd0, rise[i]}, 8'd0);
      checkOutput($sformatf("rstFall%0d", i), {7'd0, fall[i]}, 8'd0);
      checkOutput($sformatf("rstBusy%0d", i), {7'd0, busy[i]}, 8'd0);
    end
    checkOutput("rstGlitch0", gc0, 8'd0);
    checkOutput("rstGlitch1", gc1, 8'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    raw_i = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compareAll();

    // glitch of two cycles from a low level
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 8);

    // clean rise, then clean fall
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 8);

    // reset while raw_i is high and q is high, then re-debounce
    applyStimulus(1'b1, 8);
    doReset();
    applyStimulus(1'b1, 8);

    // reset in the middle of a count
    applyStimulus(1'b0, 4);
    doReset();
    applyStimulus(1'b1, 3);
    doReset();
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 8);

    // random runs with occasional resets
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 39) == 0) begin
        doReset();
      end
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
    end

    // saturation: many two-cycle glitches from a low level
    applyStimulus(1'b0, 8);
    doReset();
    for (int g = 0; g < 300; g++) begin
      applyStimulus(1'b1, 2);
      applyStimulus(1'b0, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions a raw asynchronous level input (switch/button/external pin) before it is consumed by downstream flop stages as a clean data input. Synchronises the input into clk, rejects pulses shorter than a programmable number of cycles, and emits a stable level plus single-cycle rise/fall strobes. Sits directly upstream of the register stages that take a d_i level.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on raw input (legal >= 2)
DEBOUNCE_CYCLES, 4, consecutive cycles synchronised input must differ from stable level before it is accepted (legal >= 1)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
raw_i  input  1  raw asynchronous level input
q_o  output  1  debounced stable level
rise_o  output  1  one-cycle strobe on accepted 0->1 transition
fall_o  output  1  one-cycle strobe on accepted 1->0 transition
busy_o  output  1  high while a candidate transition is being counted
glitch_cnt_o  output  8  rejected-glitch count (see Optional Feature)

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. While reset high: all synchroniser flops, counter, FSM, q_o, rise_o, fall_o, busy_o, glitch_cnt_o = 0, independent of clk.
- Synchroniser: SYNC_STAGES-flop shift chain, raw_i into stage 1; s = last stage. No logic between stages.
- FSM states: STABLE, COUNT. Counter cnt (CNT_W bits).
- STABLE: if s == q_o, stay, cnt = 0. If s != q_o and DEBOUNCE_CYCLES == 1: accept immediately (update below), stay STABLE. Else go COUNT, cnt <= 1.
- COUNT: if s == q_o: glitch rejected, cnt <= 0, go STABLE. Else if cnt == DEBOUNCE_CYCLES-1: accept, cnt <= 0, go STABLE. Else cnt <= cnt+1.
- Accept: on the same edge, q_o <= s; rise_o <= s; fall_o <= ~s. rise_o/fall_o otherwise 0; each high exactly one cycle; never both high.
- busy_o = 1 iff state == COUNT (registered state, no combinational path from raw_i).
- Latency: counting first edge that samples a new raw_i level as edge 1, q_o and strobe change after edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 6), provided raw_i holds.
- Rejection: synchronised pulse lasting < DEBOUNCE_CYCLES cycles produces no q_o change and no strobe.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Reset mid-count: count discarded, no strobe. After deassert, q_o = 0; if raw_i is high it must complete full debounce and then produce rise_o.
- Reset deassertion assumed synchronous to clk at system level; block adds no reset synchroniser.

Optional Feature:
DEBOUNCE_GLITCH_CNT_EN
- Defined: 8-bit counter increments on each COUNT->STABLE rejection, saturates at 255 (no wrap), cleared only by reset; driven on glitch_cnt_o.
- Not defined: counter logic absent, glitch_cnt_o tied to 8'd0. All other behaviour identical.

Test Plan:
- Reset check: assert reset mid-cycle with raw_i = 1 -> all outputs 0 immediately, before next clk edge.
- Clean rise (defaults): raw_i 0->1 sampled at edge 1, held -> busy_o high after edge 3, q_o = 1 and rise_o = 1 for one cycle after edge 6, busy_o 0.
- Glitch reject: raw_i high for 2 cycles then low -> q_o stays 0, no rise_o; with DEBOUNCE_GLITCH_CNT_EN glitch_cnt_o = 1, without it = 0.
- Clean fall: from q_o = 1, raw_i low held -> q_o = 0 and fall_o one cycle after edge 6; rise_o stays 0.
- Saturation (macro on): 300 glitches of 2 cycles each -> glitch_cnt_o = 255, q_o = 0 throughout.
- DEBOUNCE_CYCLES = 1: raw_i 0->1 at edge 1 -> q_o = 1, rise_o after edge 3; busy_o never high.
